// File: rtl/layer_compositor.sv
// Two-stage pixel compositor: priority mux of object layers, overlay and background,
// plus per-frame pairwise layer-overlap accumulation. Optional macro: LAYER_COMPOSITOR_BLEND_EN.
module layer_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W = 12,
  parameter logic [COLOR_W-1:0] KEY_COLOR = COLOR_W'(12'hF0F)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pixel_tick,
  input  logic                             video_on,
  input  logic                             frame_start,
  input  logic [NUM_LAYERS-1:0]            layer_on,
  input  logic [NUM_LAYERS*COLOR_W-1:0]    layer_rgb,
  input  logic [NUM_LAYERS-1:0]            layer_en,
  input  logic [COLOR_W-1:0]               bg_rgb,
  input  logic                             overlay_on,
  input  logic [COLOR_W-1:0]               overlay_rgb,
  input  logic                             overlay_en,
  output logic [COLOR_W-1:0]               rgb,
  output logic [$clog2(NUM_LAYERS+1)-1:0]  top_layer,
  output logic [NUM_LAYERS*(NUM_LAYERS-1)/2-1:0] collision_pairs,
  output logic                             collision_any,
  output logic                             collision_valid
);

  localparam int NPAIR = NUM_LAYERS * (NUM_LAYERS - 1) / 2;
  localparam int TW    = $clog2(NUM_LAYERS + 1);
  localparam int FW    = COLOR_W / 3;

  // Stage 1 registers
  logic [NUM_LAYERS-1:0]         eff_q;
  logic [NUM_LAYERS*COLOR_W-1:0] lrgb_q;
  logic [COLOR_W-1:0]            bg_q;
  logic [COLOR_W-1:0]            ov_rgb_q;
  logic                          ov_q;
  logic                          vid_q;
  logic                          fs_q;

  // Stage 2 / collision registers
  logic [COLOR_W-1:0] rgb_q;
  logic [TW-1:0]      top_q;
  logic [NPAIR-1:0]   acc_q;
  logic [NPAIR-1:0]   pairs_q;
  logic               any_q;
  logic               valid_q;

  logic [NUM_LAYERS-1:0] eff_d;
  logic [NPAIR-1:0]      ovl_d;
  logic [COLOR_W-1:0]    under_rgb;
  logic [TW-1:0]         under_idx;
  logic [COLOR_W-1:0]    ov_color;
  logic [COLOR_W-1:0]    rgb_d;
  logic [TW-1:0]         top_d;

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_eff
    assign eff_d[gi] = layer_on[gi] & layer_en[gi] &
                       (layer_rgb[gi*COLOR_W +: COLOR_W] != KEY_COLOR);
  end

  // Pair (i,j), i<j, maps to bit i*N - i*(i+1)/2 + (j-i-1)
  for (genvar gi = 0; gi < NUM_LAYERS - 1; gi++) begin : g_pi
    for (genvar gj = gi + 1; gj < NUM_LAYERS; gj++) begin : g_pj
      localparam int IDX = gi*NUM_LAYERS - gi*(gi+1)/2 + gj - gi - 1;
      assign ovl_d[IDX] = eff_q[gi] & eff_q[gj] & vid_q;
    end
  end

  always_comb begin
    under_rgb = bg_q;
    under_idx = TW'(NUM_LAYERS);
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eff_q[i]) begin
        under_rgb = lrgb_q[i*COLOR_W +: COLOR_W];
        under_idx = TW'(i);
      end
    end
  end

`ifdef LAYER_COMPOSITOR_BLEND_EN
  for (genvar gi = 0; gi < 3; gi++) begin : g_blend
    logic [FW:0] sum;
    assign sum = {1'b0, ov_rgb_q[gi*FW +: FW]} + {1'b0, under_rgb[gi*FW +: FW]};
    assign ov_color[gi*FW +: FW] = sum[FW:1];
  end
`else
  assign ov_color = ov_rgb_q;
`endif

  always_comb begin
    rgb_d = '0;
    top_d = TW'(NUM_LAYERS);
    if (vid_q) begin
      if (ov_q) begin
        rgb_d = ov_color;
      end else begin
        rgb_d = under_rgb;
        top_d = under_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eff_q    <= '0;
      lrgb_q   <= '0;
      bg_q     <= '0;
      ov_rgb_q <= '0;
      ov_q     <= 1'b0;
      vid_q    <= 1'b0;
      fs_q     <= 1'b0;
      rgb_q    <= '0;
      top_q    <= TW'(NUM_LAYERS);
    end else if (pixel_tick) begin
      eff_q    <= eff_d;
      lrgb_q   <= layer_rgb;
      bg_q     <= bg_rgb;
      ov_rgb_q <= overlay_rgb;
      ov_q     <= overlay_on & overlay_en;
      vid_q    <= video_on;
      fs_q     <= frame_start;
      rgb_q    <= rgb_d;
      top_q    <= top_d;
    end
  end

  // Frame-start pixel seeds the new frame's accumulator instead of clearing it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      pairs_q <= '0;
      any_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (pixel_tick) begin
        if (fs_q) begin
          pairs_q <= acc_q;
          any_q   <= |acc_q;
          valid_q <= 1'b1;
          acc_q   <= ovl_d;
        end else begin
          acc_q <= acc_q | ovl_d;
        end
      end
    end
  end

  assign rgb             = rgb_q;
  assign top_layer       = top_q;
  assign collision_pairs = pairs_q;
  assign collision_any   = any_q;
  assign collision_valid = valid_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed-vector bench for layer_compositor with immediate-assertion checks.
module tb_layer_compositor;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_tick;
  logic        video_on;
  logic        frame_start;
  logic [3:0]  layer_on;
  logic [47:0] layer_rgb;
  logic [3:0]  layer_en;
  logic [11:0] bg_rgb;
  logic        overlay_on;
  logic [11:0] overlay_rgb;
  logic        overlay_en;
  logic [11:0] rgb;
  logic [2:0]  top_layer;
  logic [5:0]  collision_pairs;
  logic        collision_any;
  logic        collision_valid;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_ov;

  layer_compositor dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .video_on(video_on),
    .frame_start(frame_start), .layer_on(layer_on), .layer_rgb(layer_rgb),
    .layer_en(layer_en), .bg_rgb(bg_rgb), .overlay_on(overlay_on),
    .overlay_rgb(overlay_rgb), .overlay_en(overlay_en), .rgb(rgb),
    .top_layer(top_layer), .collision_pairs(collision_pairs),
    .collision_any(collision_any), .collision_valid(collision_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_layer(input int i, input logic [11:0] c);
    layer_rgb[i*12 +: 12] = c;
  endtask

  task automatic chk_px(input string tag, input logic [11:0] c, input logic [2:0] t);
    chk({tag, "_rgb"}, {20'd0, rgb}, {20'd0, c});
    chk({tag, "_top"}, {29'd0, top_layer}, {29'd0, t});
  endtask

  task automatic chk_rep(input string tag, input logic [5:0] p);
    chk({tag, "_valid"}, {31'd0, collision_valid}, 32'd1);
    chk({tag, "_pairs"}, {26'd0, collision_pairs}, {26'd0, p});
    chk({tag, "_any"}, {31'd0, collision_any}, {31'd0, |p});
  endtask

  initial begin
`ifdef LAYER_COMPOSITOR_BLEND_EN
    exp_ov = 12'h777;
`else
    exp_ov = 12'hFFF;
`endif
    reset = 1'b1; pixel_tick = 1'b1; video_on = 1'b1; frame_start = 1'b0;
    layer_on = 4'b0001; layer_en = 4'b1111; layer_rgb = '0; set_layer(0, 12'h0F0);
    bg_rgb = 12'h888; overlay_on = 1'b0; overlay_rgb = 12'h000; overlay_en = 1'b0;
    #1; step(); step();
    chk_px("por", 12'h000, 3'd4);
    chk("por_pairs", {26'd0, collision_pairs}, 32'd0);
    chk("por_valid", {31'd0, collision_valid}, 32'd0);
    reset = 1'b0; step(); step();
    chk_px("run", 12'h0F0, 3'd0);

    // reset mid-stream: immediate, then 2-tick latency after release
    reset = 1'b1; #1;
    chk_px("rst_async", 12'h000, 3'd4);
    chk("rst_pairs", {26'd0, collision_pairs}, 32'd0);
    reset = 1'b0; step();
    chk_px("rst_tick1", 12'h000, 3'd4);
    step();
    chk_px("rst_tick2", 12'h0F0, 3'd0);

    // priority and enable mask
    layer_on = 4'b0110; set_layer(1, 12'h00F); set_layer(2, 12'hF00);
    step(); step();
    chk_px("prio", 12'h00F, 3'd1);
    layer_en = 4'b1101; step();
    chk_px("en_lat1", 12'h00F, 3'd1);
    step();
    chk_px("en_lat2", 12'hF00, 3'd2);
    layer_on = 4'b0000; step(); step();
    chk_px("bg", 12'h888, 3'd4);
    video_on = 1'b0; step(); step();
    chk_px("blank", 12'h000, 3'd4);
    video_on = 1'b1; layer_en = 4'b1111;

    // first report after reset: (1,2) overlap from priority test
    frame_start = 1'b1; step(); frame_start = 1'b0; step();
    chk_rep("rep0", 6'b001000);
    step();
    chk("rep0_pulse", {31'd0, collision_valid}, 32'd0);

    // colour key: transparent layer 0 over layer 3
    layer_on = 4'b1001; set_layer(0, 12'hF0F); set_layer(3, 12'h123);
    step(); step();
    chk_px("key", 12'h123, 3'd3);
    // 5 overlapping pixels of layers 0 and 3
    set_layer(0, 12'h0F0);
    repeat (5) step();
    chk_px("ovl", 12'h0F0, 3'd0);
    layer_on = 4'b0000; frame_start = 1'b1; step();
    frame_start = 1'b0; step();
    chk_rep("repN", 6'b000100);
    step();
    chk("repN_pulse", {31'd0, collision_valid}, 32'd0);
    chk("repN_hold", {26'd0, collision_pairs}, 32'd4);

    // frame N+1: no overlap; its frame_start pixel overlaps (0,1) and seeds N+2
    step(); step();
    frame_start = 1'b1; layer_on = 4'b0011; step();
    frame_start = 1'b0; layer_on = 4'b0000; step();
    chk_rep("repN1", 6'b000000);
    step(); step();
    frame_start = 1'b1; video_on = 1'b0; layer_on = 4'b0011; step();
    frame_start = 1'b0; video_on = 1'b1; layer_on = 4'b0000; step();
    chk_rep("repN2", 6'b000001);
    // blanked frame_start pixel seeds zero; (2,3) overlaps this frame
    layer_on = 4'b1100; step(); step();
    layer_on = 4'b0000; frame_start = 1'b1; step();
    frame_start = 1'b0; step();
    chk_rep("repN3", 6'b100000);

    // overlay
    layer_on = 4'b0001; set_layer(0, 12'h000);
    overlay_en = 1'b1; overlay_on = 1'b1; overlay_rgb = 12'hFFF;
    step(); step();
    chk_px("ovr", exp_ov, 3'd4);
    overlay_en = 1'b0; step(); step();
    chk_px("ovr_off", 12'h000, 3'd0);
    overlay_en = 1'b1; step(); step();
    chk_px("ovr_on", exp_ov, 3'd4);

    // pixel_tick low: everything frozen
    pixel_tick = 1'b0;
    for (int k = 0; k < 10; k++) begin
      layer_on = 4'($urandom); layer_rgb = 48'({$urandom, $urandom});
      bg_rgb = 12'($urandom); overlay_rgb = 12'($urandom);
      overlay_on = 1'($urandom); video_on = 1'($urandom); frame_start = 1'b1;
      step();
      chk_px("frz", exp_ov, 3'd4);
      chk("frz_pairs", {26'd0, collision_pairs}, 32'h20);
      chk("frz_any", {31'd0, collision_any}, 32'd1);
      chk("frz_valid", {31'd0, collision_valid}, 32'd0);
    end
    pixel_tick = 1'b1; frame_start = 1'b0; video_on = 1'b1; layer_on = 4'b0000;
    overlay_en = 1'b0; bg_rgb = 12'h888;
    step();
    chk_px("resume1", exp_ov, 3'd4);
    step();
    chk_px("resume2", 12'h888, 3'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised, pipelined pixel compositor that replaces the fixed if/else RGB mux in the display top level.
- Merges NUM_LAYERS object layers, an optional full-screen overlay (e.g. gameover/logo) and a background into one registered VGA RGB stream.
- Applies a transparency colour key and per-layer enables.
- Accumulates per-frame pixel-exact pairwise layer overlap, feeding the game state machine as collision input.

Parameters:
- NUM_LAYERS, 4, number of object layers; index 0 = highest priority; legal range 2..8.
- COLOR_W, 12, RGB width; must be divisible by 3 (R,G,B equal fields, R in MSBs).
- KEY_COLOR, 12'hF0F, layer pixel value treated as transparent.
- NPAIR, NUM_LAYERS*(NUM_LAYERS-1)/2, derived localparam, not overridable.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pixel_tick  in  1  pixel enable from vga_sync; all pipeline stages advance only when high
- video_on  in  1  active display area, aligned with layer inputs
- frame_start  in  1  high on the pixel_tick where x=0,y=0
- layer_on  in  NUM_LAYERS  per-layer pixel-inside-object flag
- layer_rgb  in  NUM_LAYERS*COLOR_W  layer i colour at bits [i*COLOR_W +: COLOR_W]
- layer_en  in  NUM_LAYERS  layer mask; 0 = layer invisible and excluded from collision
- bg_rgb  in  COLOR_W  background colour
- overlay_on  in  1  overlay pixel inside overlay sprite
- overlay_rgb  in  COLOR_W  overlay colour
- overlay_en  in  1  overlay globally enabled (game_state-driven)
- rgb  out  COLOR_W  composited colour to VGA DAC
- top_layer  out  $clog2(NUM_LAYERS+1)  index of visible layer; NUM_LAYERS = background/overlay
- collision_pairs  out  NPAIR  per-frame overlap flags, held for one frame
- collision_any  out  1  OR of collision_pairs
- collision_valid  out  1  one-clk pulse when collision_pairs updates

Behaviour:
- Reset (asynchronous): rgb=0, top_layer=NUM_LAYERS, collision_pairs=0, collision_any=0, collision_valid=0, all pipeline/accumulator registers cleared.
- Effective layer flag: eff[i] = layer_on[i] & layer_en[i] & (layer_rgb[i] != KEY_COLOR).
- Stage 1 (on pixel_tick): register eff, layer colours, bg, overlay, video_on, frame_start.
- Stage 2 (on pixel_tick): select colour and register to rgb/top_layer.
  - ~video_on_d: black (0).
  - Else overlay_on & overlay_en: overlay_rgb.
  - Else lowest i with eff[i]: that layer's colour.
  - Else bg_rgb.
  - top_layer = selected i, else NUM_LAYERS.
- Latency: exactly 2 pixel_ticks from input to rgb; outputs hold between ticks.
- Collision accumulator (NPAIR bits) is updated from stage-1 registers on each pixel_tick.
- Pair ordering: (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1) mapped to bits 0..NPAIR-1.
- Pair bit set when eff_d[i] & eff_d[j] & video_on_d.
- Overlap is pixel-exact and ignores the overlay.
- Frame boundary: on a tick with frame_start_d=1:
  - Copy accumulator to collision_pairs.
  - Assert collision_valid for that one clk.
  - Load accumulator with the current pixel's overlaps; do not clear it to 0, so the pixel belongs to the new frame.
- collision_any is registered together with collision_pairs.
- frame_start while ~video_on_d: accumulator reloads to 0.
- Reset mid-frame discards the partial accumulation; the first frame_start after reset reports whatever accumulated since reset.
- pixel_tick low: no state changes anywhere; collision_valid stays 0.

Optional Feature:
- Macro LAYER_COMPOSITOR_BLEND_EN.
- Defined: when the overlay wins, rgb is a per-channel 50/50 blend of the overlay and the colour that would have won without the overlay (layer or bg): each field = (a+b)>>1, truncated, computed at full field width +1.
- Undefined: the overlay fully replaces the underlying colour.
- Latency unchanged in both cases.

Test Plan:
- Reset asserted mid-stream, video_on=1, layer_on=4'b0001, layer0=12'h0F0 -> rgb=0, top_layer=4, collision_pairs=0 immediately; after release, rgb=12'h0F0 on the 2nd pixel_tick.
- layer_on=4'b0110, layer1=12'h00F, layer2=12'hF00, bg=12'h888 -> rgb=12'h00F, top_layer=1; set layer_en[1]=0 -> rgb=12'hF00, top_layer=2 two ticks later.
- layer0=KEY_COLOR 12'hF0F with layer_on[0]=1 over layer3=12'h123 -> rgb=12'h123; no (0,3) collision recorded.
- Layers 0 and 3 overlap for 5 pixels in frame N, then frame_start -> collision_valid one clk, collision_pairs=6'b000100, collision_any=1; no overlap in frame N+1 -> next report 6'b000000.
- overlay_en=1, overlay_on=1, overlay=12'hFFF over layer0=12'h000 -> rgb=12'hFFF (macro off) / 12'h777 (macro on).
- pixel_tick held low 10 clks with changing inputs -> rgb, top_layer, collision outputs unchanged, collision_valid=0.
